vga_frame_scheduler: RTL and testbench

Parametrised VGA timing engine with double-buffer swap scheduling and a pixel-return pipeline. It generates pixel coordinates for the graphics/frame-buffer side and re-times the returned colour data and syncs by a fixed fetch latency. It arbitrates frame-buffer swaps so that `active_frame` only toggles at the start of vertical blanking. It sits between the graphics driver and the VGA pins, on the pixel clock.

---
 rtl/vga_frame_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_vga_frame_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler
//   VGA timing engine for the pixel clock domain. It does three things:
//   - generates the x/y coordinates that the frame-buffer fetch logic reads,
//   - re-times the returned colour data and the raw syncs by a fixed fetch
//     latency, and
//   - schedules double-buffer swaps so that active_frame only toggles at the
//     start of vertical blanking.
//
// Ports
//   clk_i           pixel clock
//   rst_ni          asynchronous active-low reset
//   swap_req_i      one-cycle pulse: the back buffer is complete
//   pix_in_i        {r,g,b} colour, valid LAT clocks after x/y
//   x_o, y_o        current h/v counters
//   fetch_en_o      high while x/y lie inside the visible window
//   active_frame_o  buffer being displayed
//   swap_ack_o      one-cycle pulse on the cycle active_frame toggles
//   frame_start_o   high on the cycle in which x=0, y=0 are presented
//   hsync_o/vsync_o delayed syncs
//   red_o/green_o/blue_o  delayed colour, zero outside the visible window
//
// Swap FSM
//   state     | meaning
//   S_IDLE    | no swap outstanding
//   S_PENDING | swap requested; waits for the last visible line to end
module vga_frame_scheduler #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COORD_W  = 11,
    parameter int   LAT      = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               swap_req_i,
    input  logic [11:0]        pix_in_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               fetch_en_o,
    output logic               active_frame_o,
    output logic               swap_ack_o,
    output logic               frame_start_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [3:0]         red_o,
    output logic [3:0]         green_o,
    output logic [3:0]         blue_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT     = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT     = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] V_BOUND   = COORD_W'(V_ACTIVE - 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic               run_q;
    logic               active_q, active_d;
    logic               ack_q, swap_d;
    logic               fs_q, fs_d;
    logic [LAT-1:0]     fe_pipe_q, fe_pipe_d;
    logic [LAT-1:0]     hs_pipe_q, hs_pipe_d;
    logic [LAT-1:0]     vs_pipe_q, vs_pipe_d;
    logic               hs_q, vs_q;
    logic [11:0]        rgb_q;

    logic fetch_raw, hs_raw, vs_raw, boundary;

    assign fetch_raw = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_raw    = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_raw    = (v_q >= VS_START) && (v_q < VS_END);
    assign boundary  = (h_q == H_LAST) && (v_q == V_BOUND);

    // The counters hold at 0,0 for the first clock after reset release so that
    // the origin is presented together with frame_start; run_q marks the end
    // of that hold. The pipeline is frozen during the hold as well, otherwise
    // the origin would enter it twice.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (run_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        fs_d = (h_d == '0) && (v_d == '0);
    end

    // Pipeline bit 0 takes the raw value; bit LAT-1 is the oldest.
    always_comb begin
        fe_pipe_d = fe_pipe_q;
        hs_pipe_d = hs_pipe_q;
        vs_pipe_d = vs_pipe_q;
        if (run_q) begin
            fe_pipe_d = LAT'({fe_pipe_q, fetch_raw});
            hs_pipe_d = LAT'({hs_pipe_q, hs_raw});
            vs_pipe_d = LAT'({vs_pipe_q, vs_raw});
        end
    end

    // A request arriving on the boundary cycle itself is served on that same
    // boundary, so IDLE can swap directly without passing through PENDING.
    always_comb begin
        state_d = state_q;
        swap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (swap_req_i) begin
                    if (boundary) begin
                        swap_d = 1'b1;
                    end else begin
                        state_d = S_PENDING;
                    end
                end
            end
            S_PENDING: begin
                if (boundary) begin
                    swap_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        active_d = active_q ^ swap_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q       <= '0;
            v_q       <= '0;
            run_q     <= 1'b0;
            state_q   <= S_IDLE;
            active_q  <= 1'b0;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
            fe_pipe_q <= '0;
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            rgb_q     <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            run_q     <= 1'b1;
            state_q   <= state_d;
            active_q  <= active_d;
            ack_q     <= swap_d;
            fs_q      <= fs_d;
            fe_pipe_q <= fe_pipe_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            hs_q      <= hs_pipe_q[LAT-1] ? HS_POL : ~HS_POL;
            vs_q      <= vs_pipe_q[LAT-1] ? VS_POL : ~VS_POL;
            rgb_q     <= fe_pipe_q[LAT-1] ? pix_in_i : 12'h000;
        end
    end

    assign x_o            = h_q;
    assign y_o            = v_q;
    assign fetch_en_o     = fetch_raw;
    assign active_frame_o = active_q;
    assign swap_ack_o     = ack_q;
    assign frame_start_o  = fs_q;
    assign hsync_o        = hs_q;
    assign vsync_o        = vs_q;
    assign red_o          = rgb_q[11:8];
    assign green_o        = rgb_q[7:4];
    assign blue_o         = rgb_q[3:0];

endmodule

// File: tb/tb_vga_frame_scheduler.sv
module tb_vga_frame_scheduler;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int LAT = 1;
    localparam int CW = 11;
    localparam bit HP = 1'b0, VP = 1'b0;
    localparam int HT = HA + HF + HS + HB;   // 14
    localparam int VT = VA + VF + VS + VB;   // 7
    localparam int FRAME = HT * VT;          // 98

    logic          clk;
    logic          rst_n;
    logic          swap_req;
    logic [11:0]   pix_in;
    logic [CW-1:0] x, y;
    logic          fetch_en, active_frame, swap_ack, frame_start;
    logic          hsync, vsync;
    logic [3:0]    red, green, blue;

    vga_frame_scheduler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .COORD_W(CW), .LAT(LAT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .swap_req_i(swap_req), .pix_in_i(pix_in),
        .x_o(x), .y_o(y), .fetch_en_o(fetch_en), .active_frame_o(active_frame),
        .swap_ack_o(swap_ack), .frame_start_o(frame_start),
        .hsync_o(hsync), .vsync_o(vsync),
        .red_o(red), .green_o(green), .blue_o(blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: position is a pure function of the cycle index since
    // the origin was first presented.
    int t;
    int pix_hist [0:4095];
    bit m_pend, m_active, m_ack;
    int acks [0:15];

    function automatic int px(input int c);
        return (c % FRAME) % HT;
    endfunction
    function automatic int py(input int c);
        return (c % FRAME) / HT;
    endfunction
    function automatic bit f_fetch(input int c);
        return px(c) < HA && py(c) < VA;
    endfunction
    function automatic bit f_hs(input int c);
        return px(c) >= HA + HF && px(c) < HA + HF + HS;
    endfunction
    function automatic bit f_vs(input int c);
        return py(c) >= VA + VF && py(c) < VA + VF + VS;
    endfunction

    // mode 0: directed request pattern per frame; mode 1: quiet for two
    // frames, then random requests.
    function automatic bit want_req(input int mode, input int c);
        int f, xx, yy;
        f = c / FRAME; xx = px(c); yy = py(c);
        if (mode == 0) begin
            case (f)
                0: return xx == 3 && yy == 2;
                1: return (xx == 1 && yy == 0) || (xx == 5 && yy == 1) || (xx == 2 && yy == 3);
                2: return xx == HT - 1 && yy == VA - 1;
                3: return (xx == 2 && yy == 1) || (xx == HT - 1 && yy == VA - 1);
                4: return xx == 5 && yy == 5;
                6: return xx == 0 && yy == 1;
                default: return 1'b0;
            endcase
        end
        if (f < 2) return 1'b0;
        return $urandom_range(0, 14) == 0;
    endfunction

    task automatic model_reset();
        t = 0; m_pend = 1'b0; m_active = 1'b0; m_ack = 1'b0;
        for (int i = 0; i < 16; i++) acks[i] = 0;
    endtask

    task automatic run_cycles(input int n, input int mode);
        int src, exp_rgb;
        bit req;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_eq("x", int'(x), px(t));
            check_eq("y", int'(y), py(t));
            check_eq("fetch_en", int'(fetch_en), int'(f_fetch(t)));
            check_eq("frame_start", int'(frame_start), int'(t % FRAME == 0));
            src = t - LAT - 1;
            check_eq("hsync", int'(hsync), int'((src >= 0 && f_hs(src)) ? HP : !HP));
            check_eq("vsync", int'(vsync), int'((src >= 0 && f_vs(src)) ? VP : !VP));
            exp_rgb = 0;
            if (src >= 0 && f_fetch(src)) exp_rgb = pix_hist[t - 1];
            check_eq("rgb", int'({red, green, blue}), exp_rgb);
            check_eq("active_frame", int'(active_frame), int'(m_active));
            check_eq("swap_ack", int'(swap_ack), int'(m_ack));
            if (swap_ack) acks[(t / FRAME) % 16]++;

            req = want_req(mode, t);
            swap_req = req;
            pix_in = 12'($urandom);
            pix_hist[t] = int'(pix_in);

            // A swap happens on the first boundary at or after any request
            // not yet served, and becomes visible on the following cycle.
            m_ack = 1'b0;
            if (px(t) == HT - 1 && py(t) == VA - 1 && (m_pend || req)) begin
                m_ack = 1'b1;
                m_active = !m_active;
                m_pend = 1'b0;
            end else if (req) begin
                m_pend = 1'b1;
            end
            t++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_x"}, int'(x), 0);
        check_eq({tag, "_y"}, int'(y), 0);
        check_eq({tag, "_active"}, int'(active_frame), 0);
        check_eq({tag, "_ack"}, int'(swap_ack), 0);
        check_eq({tag, "_fs"}, int'(frame_start), 0);
        check_eq({tag, "_hsync"}, int'(hsync), int'(!HP));
        check_eq({tag, "_vsync"}, int'(vsync), int'(!VP));
        check_eq({tag, "_rgb"}, int'({red, green, blue}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        swap_req = 1'b0;
        pix_in = 12'h000;
        #22;
        check_reset_values("rst0");

        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_cycles(7 * FRAME + 2 * HT + 3, 0);
        check_eq("acks_f0_single", acks[0], 1);
        check_eq("acks_f1_triple_req", acks[1], 1);
        check_eq("acks_f2_boundary_req", acks[2], 1);
        check_eq("acks_f3_pend_plus_boundary", acks[3], 1);
        check_eq("acks_f4_req_in_vblank", acks[4], 0);
        check_eq("acks_f5_deferred", acks[5], 1);
        check_eq("acks_f6", acks[6], 1);
        check_eq("active_before_rst", int'(active_frame), int'(m_active));

        // Raise a request mid-frame so a swap is pending, then reset
        // asynchronously between clock edges.
        swap_req = 1'b1;
        @(posedge clk);
        #1;
        swap_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_cycles(6 * FRAME, 1);
        check_eq("acks_after_rst", acks[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
